// File: rtl/snake_pkg.sv
// Shared encodings and cell helpers for the snake game-state block and its renderer.
package snake_pkg;
    localparam int GRID_W_DEF = 100;
    localparam int GRID_H_DEF = 75;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {ST_RUN, ST_STEP, ST_FOOD, ST_OVER} state_t;

    function automatic int unsigned xy_to_pos(input int unsigned x, input int unsigned y,
                                              input int unsigned grid_w);
        return y * grid_w + x;
    endfunction

    // Renderer-side helper; the game logic itself tracks x/y and never divides.
    function automatic void pos_to_xy(input int unsigned pos, input int unsigned grid_w,
                                      output int unsigned x, output int unsigned y);
        x = pos % grid_w;
        y = pos / grid_w;
    endfunction

    function automatic logic [1:0] dir_reverse(input logic [1:0] d);
        return d ^ 2'd2;
    endfunction
endpackage

// File: rtl/snake_food_gen.sv
// Free-running food LFSR plus the range/occupancy filter that qualifies each candidate cell.
module snake_food_gen
    import snake_pkg::*;
#(
    parameter int          GRID_W    = GRID_W_DEF,
    parameter int          GRID_H    = GRID_H_DEF,
    parameter int          MAX_LEN   = 64,
    parameter int          POS_BITS  = 13,
    parameter int          LEN_BITS  = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              restart,
    input  logic [MAX_LEN-1:0][POS_BITS-1:0]  body,
    input  logic [LEN_BITS-1:0]               length,
    output logic [POS_BITS-1:0]               cand_pos,
    output logic                              cand_ok
);
    logic [15:0] lfsr;
    logic [6:0]  cand_x;
    logic [6:0]  cand_y;
    logic        hit;

    // Galois form, taps 16,14,13,11
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            lfsr <= LFSR_SEED;
        else if (restart)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign cand_x   = lfsr[6:0];
    assign cand_y   = lfsr[13:7];
    assign cand_pos = POS_BITS'(xy_to_pos(32'(cand_x), 32'(cand_y), GRID_W));

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(length) && body[i] == cand_pos)
                hit = 1'b1;
    end

    assign cand_ok = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H) && !hit;
endmodule

// File: rtl/snake_game_state.sv
// Snake game state: body shift register, length, food and collision tracking.
//  state | meaning
//  RUN   | counting frame ticks toward the next step
//  STEP  | commit one move or flag a collision
//  FOOD  | search LFSR candidates for a free cell after eating
//  OVER  | frozen after collision until start
module snake_game_state
    import snake_pkg::*;
#(
    parameter int          GRID_W    = GRID_W_DEF,
    parameter int          GRID_H    = GRID_H_DEF,
    parameter int          MAX_LEN   = 64,
    parameter int          POS_BITS  = 13,
    parameter int          START_LEN = 3,
    parameter int          MOVE_DIV  = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             frame_tick,
    input  logic [1:0]                       dir_req,
    input  logic                             dir_valid,
    input  logic                             start,
    output logic [POS_BITS*MAX_LEN-1:0]      snake_body_flat,
    output logic [$clog2(MAX_LEN+1)-1:0]     snake_length,
    output logic [POS_BITS-1:0]              food_pos,
    output logic                             game_over,
    output logic                             step_strobe
);
    localparam int LEN_BITS = $clog2(MAX_LEN+1);
    localparam int CNT_W    = $clog2(MOVE_DIV+1);
    localparam int CX       = GRID_W / 2;
    localparam int CY       = GRID_H / 2;
    localparam int CENTER   = CY * GRID_W + CX;

    function automatic logic [MAX_LEN-1:0][POS_BITS-1:0] body_image();
        logic [MAX_LEN-1:0][POS_BITS-1:0] img;
        img = '0;
        for (int i = 0; i < START_LEN; i++)
            img[i] = POS_BITS'(CENTER - i);
        return img;
    endfunction

    localparam logic [MAX_LEN-1:0][POS_BITS-1:0] BODY_INIT = body_image();

    state_t                           state;
    logic [MAX_LEN-1:0][POS_BITS-1:0] body;
    logic [POS_BITS-1:0]              head_x, head_y;
    logic [POS_BITS-1:0]              new_x, new_y, new_head;
    logic [CNT_W-1:0]                 tick_cnt;
    logic [1:0]                       dir, pending_dir, ref_dir;
    logic                             step_pending, tick_wrap, wall, eat, self_hit;
    logic                             restart;
    logic [POS_BITS-1:0]              cand_pos;
    logic                             cand_ok;

    assign snake_body_flat = body;
    assign restart   = (state == ST_OVER) && start;
    assign tick_wrap = frame_tick && (state != ST_OVER) && (tick_cnt == CNT_W'(MOVE_DIV-1));
    // A request arriving during STEP is judged against the direction being committed.
    assign ref_dir   = (state == ST_STEP) ? pending_dir : dir;

    always_comb begin
        new_x = head_x;
        new_y = head_y;
        wall  = 1'b0;
        case (pending_dir)
            DIR_UP: begin
                wall  = (head_y == '0);
                new_y = head_y - POS_BITS'(1);
            end
            DIR_DOWN: begin
                wall  = (head_y == POS_BITS'(GRID_H-1));
                new_y = head_y + POS_BITS'(1);
            end
            DIR_LEFT: begin
                wall  = (head_x == '0);
                new_x = head_x - POS_BITS'(1);
            end
            default: begin
                wall  = (head_x == POS_BITS'(GRID_W-1));
                new_x = head_x + POS_BITS'(1);
            end
        endcase
    end

    assign new_head = POS_BITS'(xy_to_pos(32'(new_x), 32'(new_y), GRID_W));
    assign eat      = (new_head == food_pos);

    // The tail only vacates when the snake does not grow on this step.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if (i < int'(snake_length) && (eat || i != int'(snake_length) - 1) && body[i] == new_head)
                self_hit = 1'b1;
    end

    snake_food_gen #(
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .MAX_LEN  (MAX_LEN),
        .POS_BITS (POS_BITS),
        .LEN_BITS (LEN_BITS),
        .LFSR_SEED(LFSR_SEED)
    ) u_food_gen (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .body    (body),
        .length  (snake_length),
        .cand_pos(cand_pos),
        .cand_ok (cand_ok)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_RUN;
            body         <= BODY_INIT;
            head_x       <= POS_BITS'(CX);
            head_y       <= POS_BITS'(CY);
            snake_length <= LEN_BITS'(START_LEN);
            food_pos     <= POS_BITS'(CENTER + GRID_W/4);
            game_over    <= 1'b0;
            step_strobe  <= 1'b0;
            tick_cnt     <= '0;
            step_pending <= 1'b0;
            dir          <= DIR_RIGHT;
            pending_dir  <= DIR_RIGHT;
        end else begin
            step_strobe <= 1'b0;
            if (state != ST_OVER) begin
                if (frame_tick)
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + CNT_W'(1);
                if (dir_valid && dir_req != dir_reverse(ref_dir))
                    pending_dir <= dir_req;
            end
            case (state)
                ST_RUN: begin
                    if (tick_wrap || step_pending) begin
                        step_pending <= 1'b0;
                        state        <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    dir <= pending_dir;
                    if (tick_wrap)
                        step_pending <= 1'b1;
                    if (wall || self_hit) begin
                        game_over <= 1'b1;
                        state     <= ST_OVER;
                    end else begin
                        for (int i = MAX_LEN-1; i > 0; i--)
                            body[i] <= body[i-1];
                        body[0]     <= new_head;
                        head_x      <= new_x;
                        head_y      <= new_y;
                        step_strobe <= 1'b1;
                        if (eat && int'(snake_length) < MAX_LEN)
                            snake_length <= snake_length + LEN_BITS'(1);
                        state <= eat ? ST_FOOD : ST_RUN;
                    end
                end
                ST_FOOD: begin
                    if (tick_wrap)
                        step_pending <= 1'b1;
                    if (cand_ok) begin
                        food_pos <= cand_pos;
                        state    <= ST_RUN;
                    end
                end
                default: begin
                    if (start) begin
                        state        <= ST_RUN;
                        body         <= BODY_INIT;
                        head_x       <= POS_BITS'(CX);
                        head_y       <= POS_BITS'(CY);
                        snake_length <= LEN_BITS'(START_LEN);
                        food_pos     <= POS_BITS'(CENTER + GRID_W/4);
                        game_over    <= 1'b0;
                        tick_cnt     <= '0;
                        step_pending <= 1'b0;
                        dir          <= DIR_RIGHT;
                        pending_dir  <= DIR_RIGHT;
                    end
                end
            endcase
        end
    end
endmodule
